// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package data_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    // Sequencer states: one decision cycle, one memory cycle, one response cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Requester identity used by the arbiter and the owner latch.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; the last-grant history lives in the parent.
module rr_arb2
    import data_mem_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_id
);

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = OWN_A;
        if (req_a && req_b) begin
            grant_id = (last_grant == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            grant_id = OWN_B;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port data memory.
// Each transaction takes three cycles: IDLE (grant + latch), ACCESS (one-cycle
// registered strobe), RESP (one-cycle ack to the owner).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    state_e              state_q, state_d;
    owner_e              last_grant_q;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;

    logic                grant_valid;
    owner_e              grant_id;
    logic                take;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .req_a       (a_req),
        .req_b       (b_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // A new transaction is accepted only when idle; req changes while busy are ignored.
    assign take = (state_q == IDLE) && grant_valid;

    // Route the winning requester's command fields.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_id == OWN_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCESS and RESP each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: memory pins are loaded on the IDLE->ACCESS edge so
    // they are registered and high for the ACCESS cycle only; read data and the
    // error flag are captured at the end of ACCESS.
    always_comb begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (take && in_range(sel_addr)) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
        end
        if (state_q == ACCESS) begin
            rdata_d = (!we_q && in_range(addr_q)) ? mem_rdata : '0;
            err_d   = ~in_range(addr_q);
        end
    end

    // Control registers: memory strobes, response capture and grant history.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            last_grant_q <= OWN_B;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if (state_q == RESP) begin
                last_grant_q <= owner_q;
            end
        end
    end

    // Command latch for the transaction in flight.
    always_ff @(posedge clk) begin
        if (take) begin
            owner_q <= grant_id;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

    // The response is presented only to the owner during RESP; everything else reads 0.
    assign a_ack   = (state_q == RESP) && (owner_q == OWN_A);
    assign b_ack   = (state_q == RESP) && (owner_q == OWN_B);
    assign a_rdata = a_ack ? rdata_q : '0;
    assign b_rdata = b_ack ? rdata_q : '0;
    assign a_err   = a_ack & err_q;
    assign b_err   = b_ack & err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a 32-word memory model on the
// memory pins, plus a transaction-level reference of memory contents.
module tb_data_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, a_err, b_ack, b_err;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write;

    logic       load_img;
    logic [7:0] env_mem [32];
    logic [7:0] ref_mem [32];
    int         nvec;
    int         nfail;
    int         dual_ack_cnt;

    data_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .b_err     (b_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset image of the memory: words 0..15 hold their index, 16..31 hold E2..F1.
    function automatic logic [7:0] img(input int i);
        return (i < 16) ? 8'(i) : 8'(8'hE2 + i - 16);
    endfunction

    // Memory model: combinational read, write on a clock edge while MemWrite is high.
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= img(i);
        end else if (mem_write && mem_addr < 8'd32) begin
            env_mem[mem_addr[4:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr < 8'd32) ? env_mem[mem_addr[4:0]] : 8'h00;

    always @(negedge clk) begin
        if (a_ack && b_ack) dual_ack_cnt <= dual_ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result of a transaction and its effect on memory, in completion order.
    task automatic ref_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                           output logic [7:0] er, output logic ee);
        ee = (addr >= 8'd32);
        er = (we || ee) ? 8'h00 : ref_mem[addr[4:0]];
        if (we && !ee) ref_mem[addr[4:0]] = wd;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (port == 1'b0) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end
    endtask

    // One isolated transaction: req in the next (IDLE) cycle, strobe one cycle
    // later, ack two cycles later, req dropped during the ack cycle.
    task automatic do_txn(input logic port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd);
        logic       legal;
        logic       got;
        int         waited;
        logic [7:0] er;
        logic       ee;
        legal = (addr < 8'd32);
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wd);
        @(posedge clk); #1;
        chk("access_read",  mem_read,  legal && !we);
        chk("access_write", mem_write, legal && we);
        chk("access_addr",  mem_addr,  legal ? addr : 8'h00);
        if (legal && we) chk("access_wdata", mem_wdata, wd);
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(posedge clk); #1;
            if ((port ? b_ack : a_ack) === 1'b1) got = 1'b1;
            else waited++;
        end
        chk("ack_seen", got, 1'b1);
        chk("ack_latency", waited, 0);
        if (got) begin
            ref_txn(we, addr, wd, er, ee);
            chk("rdata", port ? b_rdata : a_rdata, er);
            chk("err", port ? b_err : a_err, ee);
            chk("other_ack", port ? a_ack : b_ack, 1'b0);
            chk("resp_strobes", {mem_read, mem_write}, 2'b00);
        end
        drive(port, 1'b0, we, addr, wd);
    endtask

    initial begin
        logic [7:0] er;
        logic       ee;
        logic       p;
        logic       w;
        logic [7:0] ad;
        int         acks;
        int         cyc;
        int         last_cyc;
        logic       exp_owner;

        nvec = 0;
        nfail = 0;
        dual_ack_cnt = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = img(i);
        reset = 1'b1;
        load_img = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        load_img = 1'b0;

        // Reset values
        chk("rst_acks",   {a_ack, b_ack}, 2'b00);
        chk("rst_errs",   {a_err, b_err}, 2'b00);
        chk("rst_rdata",  {a_rdata, b_rdata}, 16'h0000);
        chk("rst_maddr",  mem_addr, 8'h00);
        chk("rst_mwdata", mem_wdata, 8'h00);
        chk("rst_strobe", {mem_read, mem_write}, 2'b00);
        reset = 1'b0;

        // Directed: read, write then read back, out-of-range, last legal word
        do_txn(1'b0, 1'b0, 8'd5,   8'h00);
        do_txn(1'b1, 1'b1, 8'd17,  8'hAA);
        do_txn(1'b0, 1'b0, 8'd17,  8'h00);
        do_txn(1'b0, 1'b0, 8'd32,  8'h00);
        do_txn(1'b0, 1'b0, 8'd255, 8'h00);
        do_txn(1'b0, 1'b1, 8'd32,  8'h77);
        do_txn(1'b0, 1'b0, 8'd31,  8'h00);

        // Randomized isolated transactions from either port
        for (int k = 0; k < 24; k++) begin
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255))
                                             : 8'($urandom_range(0, 31));
            do_txn(p, w, ad, 8'($urandom));
        end

        // Reset during the ACCESS cycle of a B write
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 8'd9, 8'h3C);
        @(posedge clk); #1;
        chk("rstacc_strobe", mem_write, 1'b1);
        chk("rstacc_addr", mem_addr, 8'd9);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'd9, 8'h3C);
        @(posedge clk); #1;
        chk("rstacc_noack", b_ack, 1'b0);
        chk("rstacc_strobes_off", {mem_read, mem_write}, 2'b00);
        ref_mem[9] = 8'h3C;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_noack_late", {a_ack, b_ack}, 2'b00);
        do_txn(1'b0, 1'b0, 8'd9, 8'h00);
        do_txn(1'b1, 1'b1, 8'd9, 8'h5A);
        do_txn(1'b0, 1'b0, 8'd9, 8'h00);

        // Both requesters contend continuously from reset: A, B, A, B ...
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
        acks = 0;
        cyc = 0;
        last_cyc = -1;
        exp_owner = 1'b0;
        while (acks < 12 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack || b_ack) begin
                p = b_ack;
                chk("tie_owner", p, exp_owner);
                chk("tie_gap", cyc - last_cyc, 3);
                if (p == 1'b0) ref_txn(a_we, a_addr, a_wdata, er, ee);
                else           ref_txn(b_we, b_addr, b_wdata, er, ee);
                chk("tie_rdata", p ? b_rdata : a_rdata, er);
                chk("tie_err", p ? b_err : a_err, ee);
                drive(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
                exp_owner = ~p;
                last_cyc = cyc;
                acks++;
            end
        end
        chk("tie_ack_count", acks, 12);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;

        // Final memory contents must match the reference
        for (int i = 0; i < 32; i++) chk("final_mem", env_mem[i], ref_mem[i]);
        chk("no_dual_ack", dual_ack_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
